// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter -- iterative AES-128 inverse cipher, one inverse round
// per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   ciphertext block valid
//   in_ready   block accepted when in_valid && in_ready
//   in_data    ciphertext, byte 0 = in_data[127:120], column-major
//   rk_idx     round-key index requested this cycle
//   rk_data    round key for rk_idx, combinational lookup in the same cycle
//   out_valid  plaintext valid
//   out_ready  plaintext consumed when out_valid && out_ready
//   out_data   plaintext, same byte order as in_data
//   busy       high while inverse rounds are in progress
//
// Build option:
//   AES_INV_BACK2BACK_EN  when defined, a new block may be accepted in the
//                         same cycle the finished plaintext is handed off,
//                         giving one block every NR+1 cycles.
module aes_inv_cipher_iter #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   if (NR != 10) begin : g_bad_nr
      $error("aes_inv_cipher_iter: only NR=10 (AES-128) is supported");
   end

   // Byte k of a block is element k (element 0 is the most significant byte).
   typedef logic [0:15][7:0] blk_t;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } state_t;

   localparam logic [3:0] RK_LAST = 4'(NR);

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   state_t     state;
   logic [3:0] rnd;
   blk_t       st;
   blk_t       rnd_out;

   // GF(2^8) multiply-by-2 over 0x11b and the InvMixColumns constants.
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns when mix.
   function automatic blk_t inv_round(input blk_t s, input blk_t k, input logic mix);
      blk_t       t;
      logic [7:0] a0, a1, a2, a3;
      t = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            // Row r rotated right by r columns: out column c takes input column c-r.
            t[4'(4*c + r)] = INV_SBOX[s[4'(4*((c + 4 - r) % 4) + r)]] ^ k[4'(4*c + r)];
         end
      end
      if (mix) begin
         for (int unsigned c = 0; c < 4; c++) begin
            a0 = t[4'(4*c)];
            a1 = t[4'(4*c + 1)];
            a2 = t[4'(4*c + 2)];
            a3 = t[4'(4*c + 3)];
            t[4'(4*c)]     = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
            t[4'(4*c + 1)] = mule(a1) ^ mulb(a2) ^ muld(a3) ^ mul9(a0);
            t[4'(4*c + 2)] = mule(a2) ^ mulb(a3) ^ muld(a0) ^ mul9(a1);
            t[4'(4*c + 3)] = mule(a3) ^ mulb(a0) ^ muld(a1) ^ mul9(a2);
         end
      end
      return t;
   endfunction

   always_comb begin
      rnd_out = inv_round(st, rk_data, rnd != 4'd0);
   end

   // Handshake/key-index decode; acceptance is blocked while rst is high.
   always_comb begin
      in_ready = 1'b0;
      rk_idx   = RK_LAST;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
         end
         ROUND: begin
            rk_idx = rnd;
            busy   = 1'b1;
         end
         DONE: begin
`ifdef AES_INV_BACK2BACK_EN
            in_ready = out_ready && !rst;
            rk_idx   = RK_LAST;
`else
            rk_idx   = 4'd0;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rnd       <= 4'd0;
         st        <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  st    <= in_data ^ rk_data;
                  rnd   <= RK_LAST - 4'd1;
                  state <= ROUND;
               end
            end
            ROUND: begin
               st <= rnd_out;
               if (rnd == 4'd0) begin
                  out_data  <= rnd_out;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  rnd <= rnd - 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
`ifdef AES_INV_BACK2BACK_EN
                  // Output handoff and next acceptance share this edge.
                  if (in_valid) begin
                     st    <= in_data ^ rk_data;
                     rnd   <= RK_LAST - 4'd1;
                     state <= ROUND;
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter -- scoreboard bench for aes_inv_cipher_iter.
// Round keys are served from a key-expansion model; expected plaintexts come
// from a reference FIPS-197 inverse cipher over a 4x4 byte-matrix state.
// Honours AES_INV_BACK2BACK_EN to select the expected handoff timing.
module tb_aes_inv_cipher_iter;

`ifdef AES_INV_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif
   localparam int NK = 6;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   aes_inv_cipher_iter #(.NR(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_idx    (rk_idx),
      .rk_data   (rk_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   int            cycle = 0;
   int            acc_count = 0;
   int            pending_k = 0;
   int            inflight_k = 0;
   logic [7:0]    sbox [256];
   logic [7:0]    isbox [256];
   logic [127:0]  keys [NK];
   logic [127:0]  rkt [NK][16];
   logic [127:0]  exp_q[$];
   int            acc_cyc[$];
   int            out_cyc[$];

   // Key store: rounds use the key of the block in flight, otherwise the
   // key of the block currently offered.
   assign rk_data = busy ? rkt[inflight_k][rk_idx] : rkt[pending_k][rk_idx];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cycle);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return 8'((v << n) | (v >> (8 - n)));
   endfunction

   task automatic build_sboxes();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x] = s;
         isbox[s] = 8'(x);
      end
   endtask

   task automatic expand(input int k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = keys[k][127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]] ^ rcon, sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++)
         rkt[k][r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
   endtask

   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int k);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   a [4];
      logic [127:0] rk, pt;
      rk = rkt[k][10];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ rk[127 - 8*(4*c + r) -: 8];
      for (int rd = 9; rd >= 0; rd--) begin
         rk = rkt[k][rd];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][(c + r) % 4] = s[r][c];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               s[r][c] = isbox[t[r][c]] ^ rk[127 - 8*(4*c + r) -: 8];
         if (rd > 0) begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) a[r] = s[r][c];
               for (int r = 0; r < 4; r++)
                  s[r][c] = gmul(8'h0e, a[r]) ^ gmul(8'h0b, a[(r+1)%4]) ^
                            gmul(8'h0d, a[(r+2)%4]) ^ gmul(8'h09, a[(r+3)%4]);
            end
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            pt[127 - 8*(4*c + r) -: 8] = s[r][c];
      return pt;
   endfunction

   // Monitor / scoreboard.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            out_cyc.push_back(cycle);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got %h required no output", out_data);
            end else begin
               chk("sb_data", out_data, exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_decrypt(in_data, pending_k));
            inflight_k <= pending_k;
            acc_count++;
            acc_cyc.push_back(cycle);
         end
      end
      cycle++;
   end

   task automatic send_block(input logic [127:0] ct, input int k, input bit rand_rdy);
      int n, a0;
      pending_k = k;
      in_data   = ct;
      in_valid  = 1'b1;
      a0 = acc_count;
      n = 0;
      while (acc_count == a0 && n < 100) begin
         @(posedge clk); #1;
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
         n++;
      end
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      if (acc_count == a0) timeout("send_accept");
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) timeout("wait_out_valid");
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) timeout("drain");
   endtask

   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   initial begin
      logic [127:0] held;
      int a0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
      keys[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      for (int k = 2; k < NK; k++) keys[k] = {$urandom, $urandom, $urandom, $urandom};
      build_sboxes();
      for (int k = 0; k < NK; k++) expand(k);
      chk("ks_rk10", rkt[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("idle_rk_idx", rk_idx, 10);

      // FIPS-197 C.1: latency and key index sequence.
      send_block(C1_CT, 0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("c1_rk_idx", rk_idx, 128'(9 - i));
         chk("c1_early_valid", out_valid, 0);
         chk("c1_busy", busy, 1);
      end
      @(negedge clk);
      chk("c1_valid_at_10", out_valid, 1);
      chk("c1_plaintext", out_data, C1_PT);
      chk("c1_busy_done", busy, 0);
      chk("c1_done_rk_idx", rk_idx, B2B ? 10 : 0);
      wait_drain();

      // FIPS-197 B.
      send_block(B_CT, 1, 1'b0);
      wait_out();
      chk("b_plaintext", out_data, B_PT);
      wait_drain();

      // Backpressure with a second block pending.
      out_ready = 1'b0;
      send_block(C1_CT, 0, 1'b0);
      wait_out();
      held = out_data;
      chk("bp_plaintext", held, C1_PT);
      in_data = B_CT; pending_k = 1; in_valid = 1'b1;
      a0 = acc_count;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", out_valid, 1);
         chk("bp_stable", out_data, held);
         chk("bp_in_ready", in_ready, 0);
         @(negedge clk);
      end
      chk("bp_no_accept", acc_count, a0);
      out_ready = 1'b1;
      #1 chk("bp_ready_same_cycle", in_ready, B2B);
      @(negedge clk);
      chk("bp_ready_next_cycle", in_ready, !B2B);
      chk("bp_valid_dropped", out_valid, 0);
      chk("bp_busy_next_cycle", busy, B2B);
      begin
         int n;
         n = 0;
         while (acc_count == a0 && n < 20) begin @(posedge clk); #1; n++; end
         if (acc_count == a0) timeout("bp_second_accept");
      end
      in_valid = 1'b0;
      wait_drain();

      // Reset in the 4th ROUND cycle.
      send_block(C1_CT, 0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      repeat (12) @(negedge clk);
      chk("mid_rst_no_output", out_valid, 0);
      send_block(C1_CT, 0, 1'b0);
      wait_out();
      chk("mid_rst_c1", out_data, C1_PT);
      wait_drain();

      // in_valid held through reset.
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b1; in_data = C1_CT; pending_k = 0;
      a0 = acc_count;
      @(negedge clk);
      chk("guard_in_ready_0", in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("guard_in_ready_1", in_ready, 0);
      chk("guard_busy", busy, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("guard_no_accept", acc_count, a0);
      chk("guard_ready_after", in_ready, 1);
      @(posedge clk); #1;
      chk("guard_first_accept", acc_count, a0 + 1);
      chk("guard_busy_after", busy, 1);
      in_valid = 1'b0;
      wait_drain();

      // C.1 then B streamed with out_ready high.
      acc_cyc.delete(); out_cyc.delete();
      send_block(C1_CT, 0, 1'b0);
      in_data = B_CT; pending_k = 1; in_valid = 1'b1;
      begin
         int n;
         n = 0;
         while (acc_count < a0 + 3 && n < 40) begin @(posedge clk); #1; n++; end
         if (acc_count < a0 + 3) timeout("stream_accept");
      end
      in_valid = 1'b0;
      wait_drain();
      if (acc_cyc.size() == 2 && out_cyc.size() == 2) begin
         chk("stream_accept_cycle", 128'(acc_cyc[1] - out_cyc[0]), B2B ? 0 : 1);
         chk("stream_spacing", 128'(out_cyc[1] - out_cyc[0]), B2B ? 11 : 12);
      end else begin
         timeout("stream_handshakes");
      end

      // Randomized blocks, keys and output backpressure.
      for (int b = 0; b < 24; b++) begin
         send_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, NK - 1), 1'b1);
         repeat ($urandom_range(0, 14)) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
         end
      end
      out_ready = 1'b1;
      wait_drain();
      chk("sb_drained", 128'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete by cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

endmodule
